seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_scan_if.sv | 26 ++
 rtl/hex7seg.sv | 9 +
 rtl/seg_scan.sv | 167 ++++++++++++++++
 tb/tb_seg_scan.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Entry n holds the pattern for hex digit n (index 15 listed first).
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'b0001110,
        7'b0000110,
        7'b0100001,
        7'b1000110,
        7'b0000011,
        7'b0001000,
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle of the scanner: digit data and controls in,
// anode/segment drive and frame strobe out.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    scan_clk;
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp_n;
    logic                    frame_done;

    modport master (
        output scan_clk, enable, digits, dp, load, lz_en,
        input  an, seg, dp_n, frame_done
    );

    modport slave (
        input  scan_clk, enable, digits, dp, load, lz_en,
        output an, seg, dp_n, frame_done
    );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex to active-low seven-segment decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = HEX_TABLE[hex];
endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with dead time between digits,
// frame-synchronous data update and leading-zero suppression.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input logic     clk,
    input logic     reset,
    seg_scan_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    state_t                state, state_n;
    logic [IW-1:0]         idx, idx_n;
    logic [7:0]            cnt, cnt_n;
    logic                  scan_q;
    logic                  rise;
    logic                  wrap;

    logic [DW-1:0]         pend_dig, pend_dig_n;
    logic [NUM_DIGITS-1:0] pend_dp, pend_dp_n;
    logic [DW-1:0]         act_dig, act_dig_n;
    logic [NUM_DIGITS-1:0] act_dp, act_dp_n;

    logic [NUM_DIGITS-1:0] an_q, an_n;
    logic [6:0]            seg_q, seg_n;
    logic                  dpn_q, dpn_n;
    logic                  fd_q;

    logic [3:0]            cur_hex;
    logic                  cur_dp;
    logic                  hi_zero;
    logic                  lz_blank;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] one_hot;

    assign rise = bus.scan_clk & ~scan_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            scan_q   <= 1'b0;
            pend_dig <= '0;
            pend_dp  <= '0;
            act_dig  <= '0;
            act_dp   <= '0;
            an_q     <= '1;
            seg_q    <= SEG_OFF;
            dpn_q    <= 1'b1;
            fd_q     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            scan_q   <= bus.scan_clk;
            pend_dig <= pend_dig_n;
            pend_dp  <= pend_dp_n;
            act_dig  <= act_dig_n;
            act_dp   <= act_dp_n;
            an_q     <= an_n;
            seg_q    <= seg_n;
            dpn_q    <= dpn_n;
            fd_q     <= wrap;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        wrap    = 1'b0;
        if (!bus.enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = BLANK;
                    idx_n   = '0;
                    cnt_n   = 8'(BLANK_CYCLES);
                end
                BLANK: begin
                    if (cnt <= 8'd1) begin
                        state_n = DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
                DRIVE: begin
                    if (rise) begin
                        state_n = BLANK;
                        cnt_n   = 8'(BLANK_CYCLES);
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            idx_n = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Active data only changes at a frame boundary; while idle it
    // follows pending so the first frame after enable is current.
    always_comb begin
        pend_dig_n = bus.load ? bus.digits : pend_dig;
        pend_dp_n  = bus.load ? bus.dp : pend_dp;
        act_dig_n  = act_dig;
        act_dp_n   = act_dp;
        if (wrap || state == IDLE) begin
            act_dig_n = pend_dig_n;
            act_dp_n  = pend_dp_n;
        end
    end

    always_comb begin
        cur_hex = '0;
        cur_dp  = 1'b0;
        hi_zero = 1'b1;
        one_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_n == IW'(i)) begin
                cur_hex    = act_dig_n[4*i +: 4];
                cur_dp     = act_dp_n[i];
                one_hot[i] = 1'b1;
            end
            if (IW'(i) >= idx_n && act_dig_n[4*i +: 4] != 4'd0) begin
                hi_zero = 1'b0;
            end
        end
    end

    hex7seg u_dec (
        .hex (cur_hex),
        .seg (dec_seg)
    );

    always_comb begin
        lz_blank = bus.lz_en && (idx_n != '0) && hi_zero;
        an_n     = '1;
        seg_n    = SEG_OFF;
        dpn_n    = 1'b1;
        if (state_n == DRIVE) begin
            an_n = ~one_hot;
            if (!lz_blank) begin
                seg_n = dec_seg;
                dpn_n = ~cur_dp;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp_n       = dpn_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed test of the seven-segment scanner: scan order, dead time,
// frame-synchronous load, leading zeros, enable and reset behaviour.
module tb_seg_scan;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan #(
        .NUM_DIGITS   (4),
        .BLANK_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs,
                        input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs,
                        input logic [6:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One scan_clk pulse from DRIVE, then wait out the dead time.
    task automatic advance(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_fd);
        bus.scan_clk = 1'b1;
        tick(1);
        bus.scan_clk = 1'b0;
        chk1({tag, "_fd"}, bus.frame_done, e_fd);
        chk4({tag, "_dark"}, bus.an, 4'b1111);
        tick(16);
        chk4({tag, "_an"}, bus.an, e_an);
        chk7({tag, "_seg"}, bus.seg, e_seg);
    endtask

    initial begin
        reset        = 1'b1;
        bus.scan_clk = 1'b0;
        bus.enable   = 1'b0;
        bus.digits   = '0;
        bus.dp       = '0;
        bus.load     = 1'b0;
        bus.lz_en    = 1'b0;
        tick(2);
        chk4("rst_an", bus.an, 4'b1111);
        chk7("rst_seg", bus.seg, 7'b1111111);
        chk1("rst_dpn", bus.dp_n, 1'b1);
        chk1("rst_fd", bus.frame_done, 1'b0);
        reset = 1'b0;

        // First frame 1234
        bus.digits = 16'h1234;
        bus.load   = 1'b1;
        tick(1);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        tick(1);
        chk4("start_dark0", bus.an, 4'b1111);
        tick(15);
        chk4("start_dark15", bus.an, 4'b1111);
        tick(1);
        chk4("d0_an", bus.an, 4'b1110);
        chk7("d0_seg", bus.seg, 7'b0011001);
        chk1("d0_dpn", bus.dp_n, 1'b1);
        advance("d1", 4'b1101, 7'b0110000, 1'b0);
        advance("d2", 4'b1011, 7'b0100100, 1'b0);

        // Mid-frame load must not tear the current frame
        bus.digits = 16'hABCD;
        bus.load   = 1'b1;
        tick(1);
        bus.load   = 1'b0;
        chk7("mid_hold", bus.seg, 7'b0100100);
        advance("d3", 4'b0111, 7'b1111001, 1'b0);
        advance("wrap", 4'b1110, 7'b0100001, 1'b1);
        tick(1);
        chk1("fd_pulse_end", bus.frame_done, 1'b0);

        // Edge during BLANK is ignored
        bus.scan_clk = 1'b1;
        tick(1);
        bus.scan_clk = 1'b0;
        tick(4);
        bus.scan_clk = 1'b1;
        tick(1);
        bus.scan_clk = 1'b0;
        tick(11);
        chk4("blank_edge_an", bus.an, 4'b1101);
        chk7("blank_edge_seg", bus.seg, 7'b1000110);

        // Held-high scan_clk gives one advance only
        bus.scan_clk = 1'b1;
        tick(3);
        bus.scan_clk = 1'b0;
        tick(14);
        chk4("held_an", bus.an, 4'b1011);
        chk7("held_seg", bus.seg, 7'b0000011);
        tick(20);
        chk4("held_stay", bus.an, 4'b1011);

        // Enable drop in DRIVE at idx 2, then restart
        bus.enable = 1'b0;
        tick(1);
        chk4("dis_an", bus.an, 4'b1111);
        chk7("dis_seg", bus.seg, 7'b1111111);
        tick(2);
        bus.enable = 1'b1;
        tick(1);
        chk4("reen_dark0", bus.an, 4'b1111);
        tick(15);
        chk4("reen_dark15", bus.an, 4'b1111);
        tick(1);
        chk4("reen_an", bus.an, 4'b1110);
        chk7("reen_seg", bus.seg, 7'b0100001);

        // Leading-zero suppression on 0005
        bus.enable = 1'b0;
        bus.digits = 16'h0005;
        bus.load   = 1'b1;
        tick(1);
        bus.load   = 1'b0;
        bus.lz_en  = 1'b1;
        bus.enable = 1'b1;
        tick(17);
        chk4("lz_d0_an", bus.an, 4'b1110);
        chk7("lz_d0_seg", bus.seg, 7'b0010010);
        advance("lz_d1", 4'b1101, 7'b1111111, 1'b0);
        chk1("lz_d1_dpn", bus.dp_n, 1'b1);
        advance("lz_d2", 4'b1011, 7'b1111111, 1'b0);

        // Queue 0000 with dp on digit 0 for the next frame
        bus.digits = 16'h0000;
        bus.dp     = 4'b0001;
        bus.load   = 1'b1;
        tick(1);
        bus.load   = 1'b0;
        advance("lz_d3", 4'b0111, 7'b1111111, 1'b0);
        advance("lz_zero", 4'b1110, 7'b1000000, 1'b1);
        chk1("lz_zero_dpn", bus.dp_n, 1'b0);
        advance("z_d1", 4'b1101, 7'b1111111, 1'b0);
        advance("z_d2", 4'b1011, 7'b1111111, 1'b0);
        advance("z_d3", 4'b0111, 7'b1111111, 1'b0);

        // Load coincident with wrap
        bus.digits   = 16'h00FF;
        bus.dp       = 4'b0000;
        bus.load     = 1'b1;
        bus.scan_clk = 1'b1;
        tick(1);
        bus.load     = 1'b0;
        bus.scan_clk = 1'b0;
        chk1("coin_fd", bus.frame_done, 1'b1);
        tick(16);
        chk4("coin_an", bus.an, 4'b1110);
        chk7("coin_seg", bus.seg, 7'b0001110);
        chk1("coin_dpn", bus.dp_n, 1'b1);
        advance("coin_d1", 4'b1101, 7'b0001110, 1'b0);
        advance("coin_d2", 4'b1011, 7'b1111111, 1'b0);

        // Reset mid-frame while a digit is driven
        reset = 1'b1;
        tick(1);
        chk4("mrst_an", bus.an, 4'b1111);
        chk7("mrst_seg", bus.seg, 7'b1111111);
        chk1("mrst_dpn", bus.dp_n, 1'b1);
        chk1("mrst_fd", bus.frame_done, 1'b0);
        reset = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
